rr_arb_mux: RTL and testbench
=============================

RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data word width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter NUM_IN, default 4, giving the input channel count (legal range 2..8, power of two not required).
REQ-003 The block SHALL have derived parameter SEL_W, equal to clog2(NUM_IN), giving the channel index width.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 in_data  input  NUM_IN*WIDTH  channel i data in bits [i*WIDTH +: WIDTH]; channel 0 is the legacy "a" slot, channel 3 is the legacy "d" slot.
REQ-007 in_valid  input  NUM_IN  per-channel valid.
REQ-008 in_ready  output  NUM_IN  per-channel ready, combinational.
REQ-009 out_data  output  WIDTH  registered selected word.
REQ-010 out_sel  output  SEL_W  registered index of the channel that supplied out_data.
REQ-011 out_valid  output  1  registered output valid.
REQ-012 out_ready  input  1  downstream ready.

Function
REQ-013 The block SHALL define load = !out_valid || out_ready; the output register SHALL accept a new word only when load is high.
REQ-014 The block SHALL define a transfer on channel i as in_valid[i] && in_ready[i] in the same cycle, and an output transfer as out_valid && out_ready.
REQ-015 The grant SHALL be the first index g with in_valid[g] high, searching ptr, ptr+1, ... NUM_IN-1, 0, ... ptr-1.
REQ-016 in_ready[g] SHALL equal load, and in_ready of every non-granted channel SHALL be 0; with no valid input, all in_ready SHALL be 0.
REQ-017 On a transfer from g: out_data <= in_data[g], out_sel <= g, out_valid <= 1, ptr <= g+1, with ptr wrapping from NUM_IN-1 to 0 for any NUM_IN.
REQ-018 When load is high and no input is valid: out_valid <= 0; out_data, out_sel and ptr SHALL hold.
REQ-019 When load is low: out_data, out_sel, out_valid and ptr SHALL hold, and all in_ready SHALL be 0.
REQ-020 Latency SHALL be 1 cycle from input transfer to out_valid; sustained throughput SHALL be 1 word/cycle while out_ready stays high.
REQ-021 A channel valid continuously SHALL be granted within NUM_IN consecutive input transfers (starvation-free).
REQ-022 in_ready SHALL NOT depend combinationally on out_data or out_sel.

Reset
REQ-023 While reset is high at a clk edge: out_valid <= 0, out_data <= 0, out_sel <= 0, ptr <= 0.
REQ-024 A word held in the output register when reset is asserted SHALL be discarded, and no input transfer SHALL be recorded in that cycle.
REQ-025 all in_ready SHALL be 0 in any cycle where reset is high.

Configuration
REQ-026 When macro RR_ARB_MUX_FORCE_EN is defined, the block SHALL add ports force_en (input, 1) and force_sel (input, SEL_W).
REQ-027 With RR_ARB_MUX_FORCE_EN defined and force_en high, g SHALL be force_sel when in_valid[force_sel] is high, and there SHALL be no grant otherwise.
REQ-028 With RR_ARB_MUX_FORCE_EN defined and force_en high, forced transfers SHALL NOT update ptr, and force_sel >= NUM_IN SHALL produce no grant.
REQ-029 With RR_ARB_MUX_FORCE_EN defined and force_en low, behaviour SHALL be identical to the macro-undefined build.
REQ-030 Without RR_ARB_MUX_FORCE_EN, the force ports SHALL NOT exist and arbitration SHALL be round-robin only.

Verification
REQ-031 Defaults: assert reset 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_sel=0, and in_ready=0000 throughout.
REQ-032 in_data={16'hDDDD,16'hCCCC,16'hBBBB,16'hAAAA}, all valid, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 with matching data, 1 word/cycle.
REQ-033 out_valid=1 holding 16'hAAAA, out_ready=0 for 3 cycles -> out_data stable, in_ready=0000; out_ready=1 -> next word taken the same cycle.
REQ-034 NUM_IN=3, only in_valid[2] and in_valid[0] high -> sel 2 then 0 then 2; ptr wraps from 2 to 0.
REQ-035 Reset asserted with out_valid=1 and out_sel=2 -> next cycle out_valid=0, ptr=0; first grant after release goes to channel 0.
REQ-036 RR_ARB_MUX_FORCE_EN defined, force_en=1, force_sel=2, all valid -> out_sel=2 every cycle; drop force_en -> grant order resumes from the pre-force ptr.

Source files
------------

// File: rtl/rr_arb_mux.sv
// rr_arb_mux -- round-robin arbiter feeding a one-deep registered output slot.
//
// Each cycle, at most one valid input channel is granted. The search starts at
// the channel after the one granted most recently, which makes the arbiter
// starvation-free. The granted word lands in the output register one cycle
// later, together with the index of the channel that supplied it.
//
// Parameters
//   WIDTH   data word width in bits (1..64)
//   NUM_IN  number of input channels (2..8, any count)
//   SEL_W   channel index width, derived as $clog2(NUM_IN)
//
// Ports
//   clk        rising-edge clock for all state
//   reset      synchronous active-high reset
//   in_data    channel i word in bits [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational)
//   out_data   registered selected word
//   out_sel    registered index of the channel that supplied out_data
//   out_valid  registered output valid
//   out_ready  downstream ready
//   force_en   (RR_ARB_MUX_FORCE_EN only) pin the grant to force_sel
//   force_sel  (RR_ARB_MUX_FORCE_EN only) channel to grant while forced
//
// Optional feature: define RR_ARB_MUX_FORCE_EN to add the force_en/force_sel
// ports. A forced grant only goes to force_sel when that channel is valid and
// in range, and it never moves the round-robin pointer, so normal arbitration
// resumes exactly where it left off once force_en drops.
//
// Handshake: every interface uses valid/ready. A word moves across an
// interface in a cycle where valid and ready are both high at the rising
// clock edge. Valid never waits for ready. Ready may depend on valid, but only
// through the grant decision. in_ready is derived from out_valid, out_ready,
// in_valid and the pointer, and never from out_data or out_sel.

module rr_arb_mux #(
    parameter  int WIDTH  = 16,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef RR_ARB_MUX_FORCE_EN
    ,
    input  logic                    force_en,
    input  logic [SEL_W-1:0]        force_sel
`endif
);

    logic             load;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_next;
    logic             rr_found;
    logic [SEL_W-1:0] rr_idx;
    logic             grant_found;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_moves_ptr;
    logic [WIDTH-1:0] grant_data;

    // The output slot can take a word when it is empty or is draining this cycle.
    assign load = !out_valid || out_ready;

    // Round-robin search: ptr, ptr+1, ..., NUM_IN-1, 0, ..., ptr-1.
    // ptr is always < NUM_IN, so a single subtraction handles the wrap even
    // when NUM_IN is not a power of two.
    always_comb begin : rr_search
        int idx;
        rr_found = 1'b0;
        rr_idx   = '0;
        idx      = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end
            if (!rr_found && in_valid[SEL_W'(idx)]) begin
                rr_found = 1'b1;
                rr_idx   = SEL_W'(idx);
            end
        end
    end

    always_comb begin : grant_select
        grant_found     = rr_found;
        grant_idx       = rr_idx;
        grant_moves_ptr = 1'b1;
`ifdef RR_ARB_MUX_FORCE_EN
        if (force_en) begin
            // The range test comes first, so an out-of-range force_sel never
            // grants, whatever the indexed bit reads as.
            grant_moves_ptr = 1'b0;
            grant_idx       = force_sel;
            grant_found     = (int'(force_sel) < NUM_IN) && in_valid[force_sel];
        end
`endif
    end

    // Word mux for the granted channel.
    always_comb begin : data_mux
        grant_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Only the granted channel sees ready, and only when the slot can load.
    // Reset masks all readies, so no input transfer happens in a reset cycle.
    always_comb begin : ready_gen
        in_ready = '0;
        if (!reset && load && grant_found) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    assign ptr_next = (int'(grant_idx) == NUM_IN - 1) ? '0 : grant_idx + SEL_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (grant_found) begin
                out_data  <= grant_data;
                out_sel   <= grant_idx;
                out_valid <= 1'b1;
                if (grant_moves_ptr) begin
                    ptr <= ptr_next;
                end
            end else begin
                // Slot drains with nothing behind it. Data, index and pointer hold.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Testbench for rr_arb_mux.
// Stimulus is a set of directed vectors. Each vector pushes its hand-computed
// {sel, data} results into an expected queue. A negedge monitor pops and
// compares an entry whenever the DUT completes an output transfer. Combinational
// ready, reset values and the hold behaviour get direct checks. A second
// instance with NUM_IN=3 exercises pointer wrap for a channel count that is
// not a power of two.

`timescale 1ns/1ps

module tb_rr_arb_mux;

    localparam int WIDTH = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-channel instance
    logic          reset;
    logic [63:0]   in_data;
    logic [3:0]    in_valid;
    logic [3:0]    in_ready;
    logic [15:0]   out_data;
    logic [1:0]    out_sel;
    logic          out_valid;
    logic          out_ready;
`ifdef RR_ARB_MUX_FORCE_EN
    logic          force_en;
    logic [1:0]    force_sel;
`endif

    // 3-channel instance
    logic          reset3;
    logic [47:0]   in_data3;
    logic [2:0]    in_valid3;
    logic [2:0]    in_ready3;
    logic [15:0]   out_data3;
    logic [1:0]    out_sel3;
    logic          out_valid3;
    logic          out_ready3;

    int total = 0;
    int bad   = 0;

    logic [18:0] exp_q[$];
    logic [18:0] exp3_q[$];

    rr_arb_mux #(.WIDTH(WIDTH), .NUM_IN(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef RR_ARB_MUX_FORCE_EN
        ,
        .force_en  (force_en),
        .force_sel (force_sel)
`endif
    );

    rr_arb_mux #(.WIDTH(WIDTH), .NUM_IN(3)) dut3 (
        .clk       (clk),
        .reset     (reset3),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_sel   (out_sel3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
`ifdef RR_ARB_MUX_FORCE_EN
        ,
        .force_en  (1'b0),
        .force_sel (2'd0)
`endif
    );

    // ---------------- driver tasks ----------------
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push4(input int sel, input logic [15:0] d);
        exp_q.push_back({3'(sel), d});
    endtask

    task automatic push3(input int sel, input logic [15:0] d);
        exp3_q.push_back({3'(sel), d});
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        logic [18:0] e;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mon4_unexpected: got sel=%0d data=%h, expected no word", out_sel, out_data);
            end else begin
                e = exp_q.pop_front();
                check("mon4_word", {45'd0, 1'b0, out_sel, out_data}, {45'd0, e});
            end
        end
    end

    always @(negedge clk) begin
        logic [18:0] e;
        if (!reset3 && out_valid3 && out_ready3) begin
            if (exp3_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mon3_unexpected: got sel=%0d data=%h, expected no word", out_sel3, out_data3);
            end else begin
                e = exp3_q.pop_front();
                check("mon3_word", {45'd0, 1'b0, out_sel3, out_data3}, {45'd0, e});
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] rdy4 [3];
        logic [3:0] rdy_rr [8];
        logic [2:0] rdy3 [3];

        reset      = 1'b1;
        in_data    = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        in_valid   = 4'b1111;
        out_ready  = 1'b1;
`ifdef RR_ARB_MUX_FORCE_EN
        force_en   = 1'b0;
        force_sel  = 2'd0;
`endif
        reset3     = 1'b1;
        in_data3   = {16'hCCCC, 16'hBBBB, 16'hAAAA};
        in_valid3  = 3'b000;
        out_ready3 = 1'b1;

        // Reset for two cycles with every input valid.
        for (int c = 0; c < 2; c++) begin
            next();
            @(negedge clk);
            check("rst_in_ready", 64'(in_ready), 64'h0);
            check("rst_out_valid", 64'(out_valid), 64'h0);
            check("rst_out_data", 64'(out_data), 64'h0);
            check("rst_out_sel", 64'(out_sel), 64'h0);
        end
        check("rst3_in_ready", 64'(in_ready3), 64'h0);

        // Release: all valid, out_ready high, 8 words in strict rotation.
        next();
        reset = 1'b0;
        rdy_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                   4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 8; i++) begin
            push4(i % 4, in_data[(i % 4) * 16 +: 16]);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rr_in_ready", 64'(in_ready), 64'(rdy_rr[i]));
            if (i > 0) begin
                check("rr_throughput_valid", 64'(out_valid), 64'h1);
            end
            next();
        end
        in_valid = 4'b0000;
        next();

        // Backpressure: hold AAAA for three cycles, then drain and take BBBB.
        in_valid  = 4'b0001;
        out_ready = 1'b0;
        push4(0, 16'hAAAA);
        @(negedge clk);
        check("bp_load_empty_ready", 64'(in_ready), 64'b0001);
        next();
        in_valid = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'h0);
            check("bp_out_valid", 64'(out_valid), 64'h1);
            check("bp_out_data", 64'(out_data), 64'hAAAA);
            next();
        end
        out_ready = 1'b1;
        push4(1, 16'hBBBB);
        @(negedge clk);
        check("bp_release_ready", 64'(in_ready), 64'b0010);
        next();
        in_valid = 4'b0000;
        next();

        // Reset while holding CCCC from channel 2. The word is dropped and
        // the pointer returns to 0.
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_ready", 64'(in_ready), 64'b0100);
        next();
        reset    = 1'b1;
        in_valid = 4'b1111;
        @(negedge clk);
        check("mid_rst_in_ready", 64'(in_ready), 64'h0);
        check("pre_rst_out_sel", 64'(out_sel), 64'h2);
        next();
        reset     = 1'b0;
        out_ready = 1'b1;
        push4(0, 16'hAAAA);
        @(negedge clk);
        check("post_rst_out_valid", 64'(out_valid), 64'h0);
        check("post_rst_out_sel", 64'(out_sel), 64'h0);
        check("post_rst_out_data", 64'(out_data), 64'h0);
        check("post_rst_first_grant", 64'(in_ready), 64'b0001);
        next();
        in_valid = 4'b0000;
        next();

        // Sparse requests skip idle channels (ptr=1): 1, 3, then wrap to 1.
        in_valid = 4'b1010;
        push4(1, 16'hBBBB);
        push4(3, 16'hDDDD);
        push4(1, 16'hBBBB);
        rdy4 = '{4'b0010, 4'b1000, 4'b0010};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("sparse_in_ready", 64'(in_ready), 64'(rdy4[i]));
            next();
        end
        in_valid = 4'b0000;
        next();
        @(negedge clk);
        check("idle_out_valid", 64'(out_valid), 64'h0);
        check("idle_out_sel_hold", 64'(out_sel), 64'h1);
        next();

`ifdef RR_ARB_MUX_FORCE_EN
        // Forced to channel 2 (ptr=2 here). Forcing leaves ptr alone, so
        // release resumes at 2, then 3.
        force_en  = 1'b1;
        force_sel = 2'd2;
        in_valid  = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            push4(2, 16'hCCCC);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("force_in_ready", 64'(in_ready), 64'b0100);
            next();
        end
        force_en = 1'b0;
        push4(2, 16'hCCCC);
        push4(3, 16'hDDDD);
        @(negedge clk);
        check("unforce_first", 64'(in_ready), 64'b0100);
        next();
        @(negedge clk);
        check("unforce_second", 64'(in_ready), 64'b1000);
        next();
        // Forced onto an idle channel: no grant even though others are valid.
        force_en  = 1'b1;
        force_sel = 2'd1;
        in_valid  = 4'b0101;
        @(negedge clk);
        check("force_idle_ready", 64'(in_ready), 64'h0);
        next();
        force_en = 1'b0;
        in_valid = 4'b0000;
        next();
`endif

        // 3-channel instance: one word from ch1 puts ptr at 2, then 2, 0, 2.
        reset3    = 1'b0;
        in_valid3 = 3'b010;
        push3(1, 16'hBBBB);
        @(negedge clk);
        check("n3_first_ready", 64'(in_ready3), 64'b010);
        next();
        in_valid3 = 3'b101;
        push3(2, 16'hCCCC);
        push3(0, 16'hAAAA);
        push3(2, 16'hCCCC);
        rdy3 = '{3'b100, 3'b001, 3'b100};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("n3_wrap_ready", 64'(in_ready3), 64'(rdy3[i]));
            next();
        end
        in_valid3 = 3'b000;
        next();
        next();

        // Every expected word must have been seen.
        check("sb4_drained", 64'(exp_q.size()), 64'h0);
        check("sb3_drained", 64'(exp3_q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
